// File: rtl/fcp_pkg.sv
// Shared FCP physical-layer definitions: state encodings, line constants and
// the byte framing helper used by the transmitter.
package fcp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PING = 2'd1,
      ST_SYNC = 2'd2,
      ST_DATA = 2'd3
   } fcp_state_e;

   localparam logic [7:0] CRC_POLY = 8'h31;
   localparam logic [1:0] SYNC_PAT = 2'b10;
   localparam int         BYTE_UI  = 11;
   localparam logic [7:0] ACK      = 8'h08;
   localparam logic [7:0] NACK     = 8'h03;

   // {start, data MSB first, odd parity, stop}; bit 10 goes on the line first
   function automatic logic [10:0] frame_byte(input logic [7:0] b);
      return {1'b0, b, ~^b, 1'b1};
   endfunction

endpackage

// File: rtl/fcp_crc8.sv
// Byte-wise CRC-8 update, MSB first, not reflected.
module fcp_crc8
   import fcp_pkg::*;
(
   input  logic [7:0] crc_in,
   input  logic [7:0] data,
   output logic [7:0] crc_out
);

   logic [7:0] c;

   always_comb begin
      c = crc_in ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
      end
      crc_out = c;
   end

endmodule

// File: rtl/fcp_phy_tx.sv
// FCP physical-layer transmitter: serializes ping pulses and response frames
// (SYNC, data bytes, CRC byte) at UI_CYCLES clocks per unit interval.
module fcp_phy_tx
   import fcp_pkg::*;
#(
   parameter int UI_CYCLES = 160,
   parameter int PING_UI   = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        pl_tx_en,
   input  logic        pl_tx_type,
   input  logic [15:0] pl_tx_data,
   input  logic        reset_from_master,
   output logic        tx_out,
   output logic        tx_oe,
   output logic        tx_busy,
   output logic        tx_done
);

   localparam int UI_W = (UI_CYCLES > 1) ? $clog2(UI_CYCLES) : 1;
   localparam int PC_W = $clog2(PING_UI + 1);
   localparam logic [UI_W-1:0] UI_LAST   = UI_W'(UI_CYCLES - 1);
   localparam logic [PC_W-1:0] PING_LAST = PC_W'(PING_UI - 1);
   localparam logic [3:0]      BIT_LAST  = 4'(BYTE_UI - 1);

   fcp_state_e      state_q, state_d;
   logic [UI_W-1:0] ui_cnt_q, ui_cnt_d;
   logic [PC_W-1:0] ping_cnt_q, ping_cnt_d;
   logic [3:0]      bit_idx_q, bit_idx_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [10:0]     shreg_q, shreg_d;
   logic [7:0]      crc_q, crc_d;
   logic [15:0]     data_q, data_d;
   logic            two_byte_q, two_byte_d;

   logic       ui_end, frame_end, accept, ld_is_crc;
   logic [1:0] last_byte, ld_idx;
   logic [7:0] ld_byte, crc_upd;

   assign ui_end    = (ui_cnt_q == UI_LAST);
   assign last_byte = two_byte_q ? 2'd2 : 2'd1;
   assign frame_end = ui_end &&
                      ((state_q == ST_PING && ping_cnt_q == PING_LAST) ||
                       (state_q == ST_DATA && byte_idx_q == last_byte && bit_idx_q == BIT_LAST));
   assign tx_done   = frame_end && !reset_from_master;
   assign accept    = pl_tx_en && !reset_from_master && (state_q == ST_IDLE || frame_end);

   // Byte to load next: first byte on leaving SYNC, otherwise the following one.
   // The CRC byte carries the checksum of every data byte already loaded.
   assign ld_idx    = (state_q == ST_SYNC) ? 2'd0 : byte_idx_q + 2'd1;
   assign ld_is_crc = (ld_idx == last_byte);
   assign ld_byte   = ld_is_crc ? crc_q :
                      ((two_byte_q && ld_idx == 2'd0) ? data_q[15:8] : data_q[7:0]);

   fcp_crc8 u_crc (
      .crc_in  (crc_q),
      .data    (ld_byte),
      .crc_out (crc_upd)
   );

   always_comb begin
      state_d    = state_q;
      ping_cnt_d = ping_cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shreg_d    = shreg_q;
      crc_d      = crc_q;
      data_d     = data_q;
      two_byte_d = two_byte_q;
      ui_cnt_d   = (state_q == ST_IDLE || ui_end) ? '0 : ui_cnt_q + 1'b1;

      case (state_q)
         ST_PING: begin
            if (ui_end) begin
               if (ping_cnt_q == PING_LAST) begin
                  state_d    = ST_IDLE;
                  ping_cnt_d = '0;
               end else begin
                  ping_cnt_d = ping_cnt_q + 1'b1;
               end
            end
         end
         ST_SYNC: begin
            if (ui_end) begin
               if (bit_idx_q == 4'd1) begin
                  state_d    = ST_DATA;
                  bit_idx_d  = '0;
                  byte_idx_d = '0;
                  shreg_d    = frame_byte(ld_byte);
                  crc_d      = crc_upd;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (ui_end) begin
               if (bit_idx_q == BIT_LAST) begin
                  bit_idx_d = '0;
                  if (byte_idx_q == last_byte) begin
                     state_d    = ST_IDLE;
                     byte_idx_d = '0;
                     shreg_d    = '0;
                     crc_d      = '0;
                  end else begin
                     byte_idx_d = ld_idx;
                     shreg_d    = frame_byte(ld_byte);
                     crc_d      = ld_is_crc ? crc_q : crc_upd;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  shreg_d   = {shreg_q[9:0], 1'b0};
               end
            end
         end
         default: ;
      endcase

      // Acceptance overrides the end-of-frame return to IDLE, giving no gap.
      if (accept) begin
         state_d    = pl_tx_type ? ST_SYNC : ST_PING;
         ui_cnt_d   = '0;
         ping_cnt_d = '0;
         bit_idx_d  = '0;
         byte_idx_d = '0;
         shreg_d    = '0;
         crc_d      = '0;
         data_d     = pl_tx_data;
         two_byte_d = |pl_tx_data[15:8];
      end

      if (reset_from_master) begin
         state_d    = ST_IDLE;
         ui_cnt_d   = '0;
         ping_cnt_d = '0;
         bit_idx_d  = '0;
         byte_idx_d = '0;
         shreg_d    = '0;
         crc_d      = '0;
         data_d     = '0;
         two_byte_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         ui_cnt_q   <= '0;
         ping_cnt_q <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         shreg_q    <= '0;
         crc_q      <= '0;
         data_q     <= '0;
         two_byte_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ui_cnt_q   <= ui_cnt_d;
         ping_cnt_q <= ping_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         shreg_q    <= shreg_d;
         crc_q      <= crc_d;
         data_q     <= data_d;
         two_byte_q <= two_byte_d;
      end
   end

   always_comb begin
      tx_out = 1'b0;
      case (state_q)
         ST_PING: tx_out = 1'b1;
         ST_SYNC: tx_out = bit_idx_q[0] ? SYNC_PAT[0] : SYNC_PAT[1];
         ST_DATA: tx_out = shreg_q[10];
         default: tx_out = 1'b0;
      endcase
   end

   assign tx_oe   = (state_q != ST_IDLE);
   assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fcp_phy_tx.sv
// Directed bench for fcp_phy_tx with UI_CYCLES=4: line bits, done timing,
// back-to-back frames, aborts and async reset.
module tb_fcp_phy_tx;

   localparam int UI = 4;

   localparam logic [63:0] EXP_PING = 64'hFFFF;
   localparam logic [63:0] EXP_NACK = 64'({2'b10, 11'b0_00000011_1_1, 11'b0_01010011_1_1});
   localparam logic [63:0] EXP_ACK  = 64'({2'b10, 11'b0_00001000_0_1, 11'b0_00000001_0_1,
                                           11'b0_00000110_1_1});
   localparam logic [63:0] EXP_B9   = 64'({2'b10, 11'b0_00001000_0_1, 11'b0_10111001_0_1});

   logic        clk = 1'b0;
   logic        rstn;
   logic        pl_tx_en, pl_tx_type, reset_from_master;
   logic [15:0] pl_tx_data;
   logic        tx_out, tx_oe, tx_busy, tx_done;

   int total = 0;
   int bad   = 0;

   fcp_phy_tx #(.UI_CYCLES(UI), .PING_UI(16)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .pl_tx_en          (pl_tx_en),
      .pl_tx_type        (pl_tx_type),
      .pl_tx_data        (pl_tx_data),
      .reset_from_master (reset_from_master),
      .tx_out            (tx_out),
      .tx_oe             (tx_oe),
      .tx_busy           (tx_busy),
      .tx_done           (tx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      check(tag, 64'({tx_out, tx_oe, tx_busy, tx_done}), 64'd0);
   endtask

   // Drive a request in one cycle; leaves us just after the acceptance edge.
   task automatic accept(input logic typ, input logic [15:0] dat);
      @(negedge clk);
      pl_tx_en   = 1'b1;
      pl_tx_type = typ;
      pl_tx_data = dat;
      @(posedge clk);
      #1;
      pl_tx_en   = 1'b0;
      pl_tx_data = 16'h5A5A;
   endtask

   // Watch nui UIs; optionally poke a stray request, abort, or chain a frame
   // in the last cycle.
   task automatic observe(input int nui, input logic chain, input logic ctyp,
                          input logic [15:0] cdat, input int poke_k, input int abort_k,
                          output logic [63:0] bits, output int done_at, output int oe_cnt);
      bits = '0; done_at = 0; oe_cnt = 0;
      for (int k = 1; k <= nui*UI; k++) begin
         @(negedge clk);
         if (k == poke_k) begin
            pl_tx_en = 1'b1; pl_tx_type = 1'b0; pl_tx_data = 16'hFFFF;
         end
         if (k == abort_k) begin
            reset_from_master = 1'b1; pl_tx_en = 1'b1; pl_tx_type = 1'b0;
         end
         if (chain && k == nui*UI) begin
            pl_tx_en = 1'b1; pl_tx_type = ctyp; pl_tx_data = cdat;
         end
         #1;
         if (tx_oe) oe_cnt++;
         if (tx_done && done_at == 0) done_at = k;
         if ((k-1) % UI == UI/2) bits[nui-1-(k-1)/UI] = tx_out;
         @(posedge clk);
         #1;
         pl_tx_en = 1'b0;
         reset_from_master = 1'b0;
         if (k == abort_k) break;
      end
   endtask

   initial begin
      logic [63:0] bits;
      int done_at, oe_cnt;

      rstn = 1'b0; pl_tx_en = 1'b0; pl_tx_type = 1'b0; pl_tx_data = '0;
      reset_from_master = 1'b0;
      #1;
      idle_chk("reset_out");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      idle_chk("post_reset_quiet");

      // Ping
      accept(1'b0, 16'h0000);
      observe(16, 1'b0, 1'b0, 16'h0, 0, 0, bits, done_at, oe_cnt);
      check("ping_bits", bits, EXP_PING);
      check("ping_done", 64'(done_at), 64'd64);
      check("ping_oe", 64'(oe_cnt), 64'd64);
      idle_chk("ping_idle");

      // NACK with a stray request mid-frame
      accept(1'b1, 16'h0003);
      observe(24, 1'b0, 1'b0, 16'h0, 10, 0, bits, done_at, oe_cnt);
      check("nack_bits", bits, EXP_NACK);
      check("nack_done", 64'(done_at), 64'd96);
      check("nack_oe", 64'(oe_cnt), 64'd96);
      idle_chk("nack_idle");

      // Two-byte ACK
      accept(1'b1, 16'h0801);
      observe(35, 1'b0, 1'b0, 16'h0, 0, 0, bits, done_at, oe_cnt);
      check("ack_bits", bits, EXP_ACK);
      check("ack_done", 64'(done_at), 64'd140);
      check("ack_oe", 64'(oe_cnt), 64'd140);
      idle_chk("ack_idle");

      // Ping chained straight into a response
      accept(1'b0, 16'h0000);
      observe(16, 1'b1, 1'b1, 16'h0008, 0, 0, bits, done_at, oe_cnt);
      check("chain_ping_bits", bits, EXP_PING);
      check("chain_ping_done", 64'(done_at), 64'd64);
      check("chain_ping_oe", 64'(oe_cnt), 64'd64);
      observe(24, 1'b0, 1'b0, 16'h0, 0, 0, bits, done_at, oe_cnt);
      check("chain_rsp_bits", bits, EXP_B9);
      check("chain_rsp_done", 64'(done_at), 64'd96);
      check("chain_rsp_oe", 64'(oe_cnt), 64'd96);
      idle_chk("chain_idle");

      // Abort mid DATA
      accept(1'b1, 16'h0801);
      observe(35, 1'b0, 1'b0, 16'h0, 0, 60, bits, done_at, oe_cnt);
      check("abort_mid_done", 64'(done_at), 64'd0);
      idle_chk("abort_mid_idle");
      repeat (3) @(posedge clk);
      #1;
      idle_chk("abort_mid_stays");

      // Abort in the would-be done cycle, with a competing request
      accept(1'b1, 16'h0801);
      observe(35, 1'b0, 1'b0, 16'h0, 0, 140, bits, done_at, oe_cnt);
      check("abort_end_done", 64'(done_at), 64'd0);
      idle_chk("abort_end_drop");

      // Normal ping after aborts
      accept(1'b0, 16'h0000);
      observe(16, 1'b0, 1'b0, 16'h0, 0, 0, bits, done_at, oe_cnt);
      check("ping2_bits", bits, EXP_PING);
      check("ping2_done", 64'(done_at), 64'd64);

      // Async reset mid-frame
      accept(1'b0, 16'h0000);
      repeat (10) @(posedge clk);
      #3;
      check("pre_rst_oe", 64'(tx_oe), 64'd1);
      rstn = 1'b0;
      #1;
      idle_chk("async_rst");
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      idle_chk("async_rst_quiet");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
